// File: rtl/pulse_clkgen_pkg.sv
// Shared types and defaults for the fractional clock-enable generator.
// Default ratio 5/8 turns the 16 MHz fabric clock into a 10 MHz enable rate.
package pulse_clkgen_pkg;

    localparam int unsigned ACC_W_DEFAULT  = 16;
    localparam int unsigned INC_16M_TO_10M = 5;
    localparam int unsigned MOD_16M_TO_10M = 8;

    // Widest channel index (16 channels) and widest supported ratio operand.
    localparam int unsigned CH_IDX_W    = 4;
    localparam int unsigned RATIO_MAX_W = 32;

    typedef logic [CH_IDX_W-1:0]    ch_idx_t;
    typedef logic [RATIO_MAX_W-1:0] ratio_t;

    typedef struct packed {
        ch_idx_t ch;
        ratio_t  inc;
        ratio_t  mod;
    } cfg_req_t;

    // A request is usable only with a non-zero modulus, INC <= MOD and an existing channel.
    function automatic logic cfg_is_valid(input cfg_req_t req, input int unsigned num_ch);
        return (req.mod != '0) && (req.inc <= req.mod) && (32'(req.ch) < num_ch);
    endfunction

endpackage

// File: rtl/phase_accumulator_channel.sv
// One rational-ratio enable channel: phase accumulator, shadow ratio with
// tick-aligned apply, lock counter and optional divide-by-two square output.
// Optional feature macro: PULSE_CLKGEN_SQUARE_OUT_EN (adds o_square).
module phase_accumulator_channel
    import pulse_clkgen_pkg::*;
#(
    parameter int unsigned ACC_W       = ACC_W_DEFAULT,
    parameter int unsigned DEFAULT_INC = INC_16M_TO_10M,
    parameter int unsigned DEFAULT_MOD = MOD_16M_TO_10M,
    parameter int unsigned LOCK_TICKS  = 4
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [ACC_W-1:0] i_inc,
    input  logic [ACC_W-1:0] i_mod,
`ifdef PULSE_CLKGEN_SQUARE_OUT_EN
    output logic             o_square,
`endif
    output logic             o_tick,
    output logic             o_locked,
    output logic             o_pending
);

    localparam int unsigned CNT_W = (LOCK_TICKS > 0) ? $clog2(LOCK_TICKS + 1) : 1;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_mod;
    logic [ACC_W-1:0] r_sh_inc;
    logic [ACC_W-1:0] r_sh_mod;
    logic             r_pending;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_tick;
    logic             r_locked;

    logic [ACC_W:0]   w_sum;
    logic             w_hit;
    logic             w_apply;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_hit = (w_sum >= {1'b0, r_mod});
    // A disabled channel never ticks, so its shadow is taken on the next edge instead.
    assign w_apply = r_pending && (w_hit || (r_inc == '0));

    // Phase accumulator and active ratio; restart from zero when a new ratio is applied.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_inc <= ACC_W'(DEFAULT_INC);
            r_mod <= ACC_W'(DEFAULT_MOD);
        end else if (w_apply) begin
            r_acc <= '0;
            r_inc <= r_sh_inc;
            r_mod <= r_sh_mod;
        end else if (w_hit) begin
            r_acc <= w_sum[ACC_W-1:0] - r_mod;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

    // Shadow ratio and pending flag; a load never coincides with an apply since the port is busy while pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_inc  <= '0;
            r_sh_mod  <= '0;
            r_pending <= 1'b0;
        end else if (i_load) begin
            r_sh_inc  <= i_inc;
            r_sh_mod  <= i_mod;
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end
    end

    // Registered strobe; the apply-edge tick still belongs to the old ratio.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_hit;
        end
    end

    // Lock counter saturates at LOCK_TICKS; lock is reported one edge after the count is reached.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (w_apply) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            if (w_hit && (r_lock_cnt != CNT_W'(LOCK_TICKS))) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
            r_locked <= (r_lock_cnt == CNT_W'(LOCK_TICKS)) && (r_inc != '0);
        end
    end

`ifdef PULSE_CLKGEN_SQUARE_OUT_EN
    logic r_square;

    // Divide-by-two of the tick stream, restarted low on every apply.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_square <= 1'b0;
        end else if (w_apply) begin
            r_square <= 1'b0;
        end else if (w_hit) begin
            r_square <= ~r_square;
        end
    end

    assign o_square = r_square;
`endif

    assign o_tick    = r_tick;
    assign o_locked  = r_locked;
    assign o_pending = r_pending;

endmodule

// File: rtl/fractional_clock_enable_generator.sv
// NUM_CH independent f_in*INC/MOD clock-enable strobes with a shared
// valid/ready configuration port, error pulse and per-channel lock.
// Optional feature macro: PULSE_CLKGEN_SQUARE_OUT_EN (adds CLK_Square_Output).
module fractional_clock_enable_generator
    import pulse_clkgen_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned ACC_W       = ACC_W_DEFAULT,
    parameter  int unsigned DEFAULT_INC = INC_16M_TO_10M,
    parameter  int unsigned DEFAULT_MOD = MOD_16M_TO_10M,
    parameter  int unsigned LOCK_TICKS  = 4,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic              CLK_Input,
    input  logic              RESETN_Input,
    input  logic              CFG_Valid_Input,
    output logic              CFG_Ready_Output,
    input  logic [CH_W-1:0]   CFG_Channel_Input,
    input  logic [ACC_W-1:0]  CFG_Inc_Input,
    input  logic [ACC_W-1:0]  CFG_Mod_Input,
    output logic              CFG_Error_Output,
`ifdef PULSE_CLKGEN_SQUARE_OUT_EN
    output logic [NUM_CH-1:0] CLK_Square_Output,
`endif
    output logic [NUM_CH-1:0] Tick_Output,
    output logic [NUM_CH-1:0] Locked_Output
);

    localparam int unsigned PAD_W = 1 << CH_W;

    cfg_req_t          w_req;
    logic              w_req_ok;
    logic              w_accept;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_load;
    logic [PAD_W-1:0]  w_pend_pad;
    logic              r_cfg_err;

    // Widen the request into the package struct so validation is width-independent.
    always_comb begin
        w_req     = '0;
        w_req.ch  = ch_idx_t'(CFG_Channel_Input);
        w_req.inc = ratio_t'(CFG_Inc_Input);
        w_req.mod = ratio_t'(CFG_Mod_Input);
    end

    assign w_req_ok = cfg_is_valid(w_req, NUM_CH);

    // Non-existent channel indices read as not pending, so such requests are consumed and flagged.
    assign w_pend_pad       = PAD_W'(w_pending);
    assign CFG_Ready_Output = ~w_pend_pad[CFG_Channel_Input];
    assign w_accept         = CFG_Valid_Input && CFG_Ready_Output;

    // One-cycle error pulse for a consumed but unusable request.
    always_ff @(posedge CLK_Input or negedge RESETN_Input) begin
        if (!RESETN_Input) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && !w_req_ok;
        end
    end

    assign CFG_Error_Output = r_cfg_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = w_accept && w_req_ok && (CFG_Channel_Input == CH_W'(g));

        phase_accumulator_channel #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC),
            .DEFAULT_MOD (DEFAULT_MOD),
            .LOCK_TICKS  (LOCK_TICKS)
        ) u_ch (
            .i_clk     (CLK_Input),
            .i_rst_n   (RESETN_Input),
            .i_load    (w_load[g]),
            .i_inc     (CFG_Inc_Input),
            .i_mod     (CFG_Mod_Input),
`ifdef PULSE_CLKGEN_SQUARE_OUT_EN
            .o_square  (CLK_Square_Output[g]),
`endif
            .o_tick    (Tick_Output[g]),
            .o_locked  (Locked_Output[g]),
            .o_pending (w_pending[g])
        );
    end

endmodule

// File: tb/tb_fractional_clock_enable_generator.sv
// Directed bench for fractional_clock_enable_generator (4 channels, 5/8 default).
// Edge numbers count rising edges after reset release; outputs sampled 1 time unit after each edge.
module tb_fractional_clock_enable_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_inc = '0;
    logic [15:0] cfg_mod = '0;
    logic        cfg_err;
    logic [3:0]  tick;
    logic [3:0]  locked;
`ifdef PULSE_CLKGEN_SQUARE_OUT_EN
    logic [3:0]  square;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned edge_n = 0;
    int unsigned tick_cnt [4];

    // Default 5/8 pattern indexed by edge mod 8: ticks at residues 0,2,4,5,7.
    logic [7:0]  def_pat = 8'hB5;

    // Expected windows, index 0 = first edge of the window.
    logic [3:0]  t2_tick [14] = '{4'h0, 4'hD, 4'hF, 4'h0, 4'hD, 4'hF, 4'h0,
                                  4'hD, 4'h2, 4'hD, 4'hD, 4'h2, 4'hD, 4'hD};
    logic [3:0]  t3_tick [16] = '{4'h2, 4'hD, 4'h0, 4'hF, 4'h5, 4'h0, 4'h7, 4'h5,
                                  4'h8, 4'hF, 4'h8, 4'hD, 4'hF, 4'h8, 4'hD, 4'hF};
    logic [3:0]  t3_lock [16] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7,
                                  4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [15:0] t3_rdy = 16'b1111_1111_1011_1011;
    logic [15:0] t3_err = 16'h0001;

    fractional_clock_enable_generator #(
        .NUM_CH      (4),
        .ACC_W       (16),
        .DEFAULT_INC (5),
        .DEFAULT_MOD (8),
        .LOCK_TICKS  (4)
    ) dut (
        .CLK_Input         (clk),
        .RESETN_Input      (rst_n),
        .CFG_Valid_Input   (cfg_valid),
        .CFG_Ready_Output  (cfg_ready),
        .CFG_Channel_Input (cfg_ch),
        .CFG_Inc_Input     (cfg_inc),
        .CFG_Mod_Input     (cfg_mod),
        .CFG_Error_Output  (cfg_err),
`ifdef PULSE_CLKGEN_SQUARE_OUT_EN
        .CLK_Square_Output (square),
`endif
        .Tick_Output       (tick),
        .Locked_Output     (locked)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        for (int i = 0; i < 4; i++) tick_cnt[i] += 32'(tick[i]);
    endtask

    task automatic restart_count();
        edge_n = 0;
        for (int i = 0; i < 4; i++) tick_cnt[i] = 0;
    endtask

    task automatic run_default(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            step();
            check_eq("dflt_tick", 32'(tick), {28'h0, {4{def_pat[edge_n % 8]}}});
            check_eq("dflt_lock", 32'(locked), (edge_n >= 8) ? 32'hF : 32'h0);
            check_eq("dflt_err", 32'(cfg_err), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tick", 32'(tick), 32'h0);
        check_eq("rst_lock", 32'(locked), 32'h0);
        check_eq("rst_err", 32'(cfg_err), 32'h0);
        check_eq("rst_ready", 32'(cfg_ready), 32'h1);
        rst_n = 1'b1;
        restart_count();

        // Defaults: pattern, lock after 4th tick, 500 ticks in 800 edges
        run_default(16);
        while (edge_n < 800) step();
        for (int i = 0; i < 4; i++) check_eq("cnt800", tick_cnt[i], 32'd500);

        // ch1 -> 1/3: accepted at 801, applied on its tick at 802
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'd1; cfg_mod = 16'd3;
        #1 check_eq("t2_ready_pre", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check_eq("t2_tick801", 32'(tick), 32'h0);
        check_eq("t2_ready_ch1", 32'(cfg_ready), 32'h0);
        cfg_valid = 1'b1;
        #1 check_eq("t2_busy_ch1", 32'(cfg_ready), 32'h0);
        cfg_ch = 2'd0;
        #1 check_eq("t2_free_ch0", 32'(cfg_ready), 32'h1);
        cfg_valid = 1'b0; cfg_ch = 2'd1;
        step();
        check_eq("t2_tick802", 32'(tick), 32'hF);
        check_eq("t2_lock802", 32'(locked), 32'hD);
        for (int i = 0; i < 14; i++) begin
            step();
            check_eq("t2_tick", 32'(tick), 32'(t2_tick[i]));
            check_eq("t2_lock", 32'(locked), (edge_n >= 815) ? 32'hF : 32'hD);
            check_eq("t2_err", 32'(cfg_err), 32'h0);
        end

        // ch2 INC>MOD rejected at 817; ch3 disabled (apply 820) then INC=MOD (accept 823)
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 16'd9; cfg_mod = 16'd8;
        #1 check_eq("t3_ready_pre", 32'(cfg_ready), 32'h1);
        for (int i = 0; i < 16; i++) begin
            step();
            check_eq("t3_tick", 32'(tick), 32'(t3_tick[i]));
            check_eq("t3_lock", 32'(locked), 32'(t3_lock[i]));
            check_eq("t3_ready", 32'(cfg_ready), 32'(t3_rdy[i]));
            check_eq("t3_err", 32'(cfg_err), 32'(t3_err[i]));
            case (i)
                0, 2, 6: cfg_valid = 1'b0;
                1: begin cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'd0; cfg_mod = 16'd8; end
                5: begin cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'd8; cfg_mod = 16'd8; end
                default: ;
            endcase
        end

        // Reset while ch1 has a pending config
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'd2; cfg_mod = 16'd5;
        step();
        cfg_valid = 1'b0;
        check_eq("t6_tick833", 32'(tick), 32'h8);
        check_eq("t6_pending", 32'(cfg_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tick", 32'(tick), 32'h0);
        check_eq("t6_rst_lock", 32'(locked), 32'h0);
        check_eq("t6_rst_err", 32'(cfg_err), 32'h0);
        check_eq("t6_rst_ready", 32'(cfg_ready), 32'h1);
        step();
        step();
        check_eq("t6_hold_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        restart_count();
        run_default(16);

        // Zero modulus rejected, ch0 keeps ticking
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd0; cfg_mod = 16'd0;
        step();
        cfg_valid = 1'b0;
        check_eq("t7_err", 32'(cfg_err), 32'h1);
        check_eq("t7_ready", 32'(cfg_ready), 32'h1);
        step();
        check_eq("t7_err_clr", 32'(cfg_err), 32'h0);
        check_eq("t7_tick", 32'(tick), 32'hF);
        check_eq("t7_lock", 32'(locked), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fractional_clock_enable_generator.md
# fractional_clock_enable_generator

Parametrised successor to the payload FPGA's fixed 16→10 MHz PLL conversion: derives `NUM_CH` independent rational-ratio clock-enable strobes (f_out = f_in·INC/MOD) from the single 16 MHz fabric clock using per-channel phase accumulators. Each channel's ratio can be reprogrammed at runtime through a valid/ready configuration port, and each channel reports its own lock status. It sits beside the PLL wrapper and feeds the enables to payload peripherals that need non-integer rates without consuming another PLL.

## Interface
- `NUM_CH`, 4: number of independent enable channels (1–16).
- `ACC_W`, 16: width of the accumulator, INC and MOD.
- `DEFAULT_INC`, 5: INC loaded into every channel at reset.
- `DEFAULT_MOD`, 8: MOD loaded into every channel at reset; 5/8 of 16 MHz gives 10 MHz.
- `LOCK_TICKS`, 4: number of ticks after a config is applied before `Locked_Output` asserts.
- `CLK_Input  in  1  fabric clock (16 MHz)`
- `RESETN_Input  in  1  asynchronous active-low reset`
- `CFG_Valid_Input  in  1  config request valid`
- `CFG_Ready_Output  out  1  config port can accept; = ~pending[CFG_Channel_Input]`
- `CFG_Channel_Input  in  $clog2(NUM_CH) (min 1)  target channel`
- `CFG_Inc_Input  in  ACC_W  new INC`
- `CFG_Mod_Input  in  ACC_W  new MOD`
- `CFG_Error_Output  out  1  one-cycle pulse: accepted request rejected as invalid`
- `Tick_Output  out  NUM_CH  per-channel one-cycle enable strobe`
- `Locked_Output  out  NUM_CH  per-channel ratio stable`

## Operation
- Reset values: accumulators 0, INC/MOD = defaults, pending 0, tick counters 0, `Tick_Output` 0, `Locked_Output` 0, `CFG_Error_Output` 0, `CFG_Ready_Output` 1.
- Per channel, every cycle: sum = acc + INC, computed at ACC_W+1 bits. If sum ≥ MOD, then acc ← sum − MOD and tick; otherwise acc ← sum. Invariant acc < MOD and INC ≤ MOD, so a single subtraction suffices.
- INC = 0: channel disabled. No ticks, `Locked_Output` held 0. INC = MOD: tick every cycle.
- Config handshake: a transfer occurs on the edge where valid && ready. A request is invalid if MOD = 0, INC > MOD, or channel ≥ NUM_CH. An invalid request is still consumed; it pulses `CFG_Error_Output` on the next cycle and changes nothing.
- A valid request loads the channel's shadow INC/MOD and sets `pending`. While `pending` is set, the port is not ready for that channel; other channels are unaffected.
- Apply point (glitch-free): a pending shadow is applied in the cycle the channel ticks. At that point acc ← 0, INC/MOD ← shadow, pending cleared, lock counter cleared, and `Locked_Output` deasserted. If the channel is disabled, the shadow is applied on the cycle after acceptance.
- Simultaneous accept and tick on the same cycle: the shadow is loaded, and the apply waits for the next tick. The current tick uses the old ratio.
- Lock: the counter increments per tick, saturating at LOCK_TICKS. `Locked_Output` is 1 while the counter equals LOCK_TICKS.
- Reset mid-operation: everything returns to reset values asynchronously, including a pending shadow, which is discarded.

## Timing
- `Tick_Output` is registered: it is high in the cycle after the edge where sum ≥ MOD.
- With defaults, ticks occur on edges 2, 4, 5, 7, 8 of every 8-edge period after reset release. That is 5 ticks per 8 cycles, with no drift.
- `CFG_Ready_Output` is combinational from the pending register and channel select.
- `CFG_Error_Output` has one cycle of latency.
- `Locked_Output` rises 1 cycle after the LOCK_TICKS-th post-apply tick.

## Configuration
- `PULSE_CLKGEN_SQUARE_OUT_EN`: when defined, adds the output port `CLK_Square_Output [NUM_CH]`. Each bit is a registered flip-flop toggling on each tick (frequency f_tick/2), reset 0, and cleared when a new config is applied.
- Without the macro, the port and its flops do not exist.

## Structure
- Shared package `pulse_clkgen_pkg`: `ACC_W` default, channel-index type, config request struct (channel/inc/mod), defaults for the 16→10 MHz ratio.
- Sub-module `phase_accumulator_channel`, one instance per channel: accumulator, shadow registers, pending flag, lock counter, optional square flop. The top level holds the config decode, error pulse and ready mux.

## Test plan
- Reset release with defaults, run 800 cycles → exactly 500 ticks on every channel; `Locked_Output` = all ones after the 4th tick.
- Write ch1 INC=1 MOD=3 → ch1 keeps its 5/8 pattern until its next tick, then ticks every 3rd cycle. `Locked_Output[1]` drops on apply and rises after 4 ticks. Other channels are undisturbed.
- Write ch2 INC=9 MOD=8 → `CFG_Error_Output` pulses once, ch2 is unchanged, ready stays 1.
- Second write to ch1 while pending → `CFG_Ready_Output` = 0 for ch1 and 1 for ch0 in the same cycle.
- Write ch3 INC=0 MOD=8, then INC=8 MOD=8 → ch3 is silent and unlocked, then ticks every cycle starting 2 cycles after the second accept.
- Assert reset mid-pending → all outputs return to reset values; the pending config is lost and default ticking resumes.
